packet_receiver: RTL and testbench
==================================

# packet_receiver

Receive side of the board's Ethernet link: accepts demultiplexed RGMII-style receive data from the PHY receive path and delineates frames (preamble/SFD). Checks CRC-32 and the EtherType, and stores one accepted payload in a single-frame buffer that the housekeeping CPU reads through its input ports. It is the counterpart to the transmit-only packet streamer and carries host-to-board control packets.

## Interface
Parameters:
- MAX_PAYLOAD, 64: maximum payload bytes stored, excluding FCS; buffer depth is MAX_PAYLOAD+4.
- ETHERTYPE, 16'h88B5: EtherType a frame must carry to be accepted.
- MAC_ADDR, 48'h02_00_00_00_00_01: station address used by the destination filter.

Ports:
- clk  in  1: single clock, driven from phy_rx_clk at instantiation.
- reset  in  1: asynchronous, active-high.
- rx_data  in  8: receive byte, valid when rx_ctl[1]=1.
- rx_ctl  in  2: [1]=RX_DV; [0]=RX_DV xor RX_ER; error = rx_ctl[1]^rx_ctl[0].
- frame_ready  out  1: buffer holds an accepted frame.
- frame_len  out  7: payload length in bytes, 0..MAX_PAYLOAD; valid while frame_ready.
- rd_addr  in  7: buffer byte address.
- rd_data  out  8: buffer byte at rd_addr, registered.
- ack  in  1: one-cycle pulse that releases the buffer.
- cnt_clr  in  1: clears all counters.
- good_count  out  8: accepted frames, saturating.
- crc_err_count  out  8: CRC failures plus RX_ER frames, saturating.
- drop_count  out  8: frames lost to a busy buffer or oversize, saturating.

## Operation
- States: WAIT_IDLE, IDLE, PREAMBLE, HEADER, PAYLOAD, CHECK, DISCARD.
- WAIT_IDLE is the reset state. Transition to IDLE after one cycle with RX_DV=0. A frame in flight at reset release is never accepted.
- IDLE -> PREAMBLE on RX_DV=1 with byte 0x55. IDLE -> PREAMBLE -> HEADER on byte 0xD5.
- Any other byte in PREAMBLE -> DISCARD. RX_DV=0 in PREAMBLE -> IDLE.
- At the SFD, if frame_ready=1: go to DISCARD and increment drop_count. The busy check is made only at the SFD.
- HEADER covers 14 bytes: destination (6), source (6), EtherType (2, big-endian).
- EtherType mismatch -> DISCARD, with no counter change.
- PAYLOAD writes each byte at index n to buffer[n]. Byte MAX_PAYLOAD+4 (0-based) -> DISCARD and increment drop_count.
- RX_DV falling in HEADER or PAYLOAD -> CHECK.
- CRC: reflected CRC-32 (poly 0xEDB88320, LSB-first), initialised to 0xFFFFFFFF at the SFD. It runs over destination through FCS.
- A frame is good when the register equals 0xDEBB20E3 after the last byte, and at least 4 bytes were stored after the header.
- CHECK, good frame: frame_len = stored-4, frame_ready <= 1, good_count++.
- CHECK, bad CRC or short frame: crc_err_count++, and frame_ready is unchanged.
- CHECK always returns to IDLE.
- RX error (RX_DV=1 with error=1) in HEADER/PAYLOAD -> DISCARD and crc_err_count++.
- DISCARD holds until RX_DV=0, then goes to IDLE.
- ack with frame_ready=1 clears frame_ready on the next edge. ack with frame_ready=0 is ignored.
- cnt_clr zeroes all three counters on the next edge. It takes priority over a same-cycle increment.
- Counters hold at 255.

## Timing
- Reset values: frame_ready=0, frame_len=0, rd_data=0, all counters=0, state=WAIT_IDLE.
- rd_data reflects rd_addr sampled at the previous edge (1-cycle latency). It is undefined above frame_len-1.
- frame_ready rises 2 cycles after the first cycle with RX_DV=0: one cycle for the final CRC compare, one for commit.
- frame_len and counter updates are visible in the same cycle that frame_ready rises.
- ack asserted in the cycle frame_ready rises is honoured: frame_ready falls on the next edge.
- Buffer contents are stable while frame_ready=1. Frames arriving in that window never write the buffer.
- Back-to-back frames with a 1-cycle RX_DV gap must be handled.

## Configuration
- PACKET_RECEIVER_DEST_FILTER_EN defined: destination must equal MAC_ADDR or ff:ff:ff:ff:ff:ff. Otherwise go to DISCARD with no counter change; the check is made on the 6th header byte.
- Undefined: destination is ignored, and frames are accepted on EtherType and CRC only.

## Test plan
- Test 1, valid frame:
  - Stimulus: 7×0x55, 0xD5, broadcast destination, EtherType 0x88B5, 46 payload bytes 0x00..0x2D, correct FCS.
  - Response: frame_ready=1 two cycles after RX_DV falls; frame_len=46; rd_addr=5 returns 0x05; good_count=1.
- Test 2, corrupted FCS: same frame with bit 0 of the last FCS byte flipped.
  - Response: frame_ready stays 0; crc_err_count=1.
- Test 3, busy buffer:
  - Stimulus: second valid frame while frame_ready=1 and unacked, then ack, then a third frame.
  - Response: drop_count=1; the buffer still holds frame 1 until ack; frame 3 is accepted with good_count=2.
- Test 4, oversize: payload of MAX_PAYLOAD+1 bytes plus FCS.
  - Response: drop_count=1; no frame_ready; the next valid frame is accepted.
- Test 5, mid-frame error:
  - Stimulus: reset asserted mid-payload and released while RX_DV is still 1; then a frame with RX_ER during byte 20.
  - Response: the first frame is ignored with no counter change; the second gives crc_err_count=1.
- Test 6, filter (macro defined): unicast destination 02:00:00:00:00:02 with valid CRC.
  - Response: discarded, all counters 0.
  - Same frame with the macro undefined: accepted.

Source files
------------

// File: rtl/packet_receiver.sv
// packet_receiver
//   Receive side of the board Ethernet link. Delineates frames from
//   demultiplexed RGMII-style receive bytes (preamble/SFD), checks the
//   EtherType and the CRC-32, and holds one accepted payload in a
//   single-frame buffer that the housekeeping CPU reads and then releases
//   with ack.
//
//   Optional feature: define PACKET_RECEIVER_DEST_FILTER_EN to accept only
//   frames addressed to MAC_ADDR or to broadcast. Without it, the
//   destination address is ignored.
//
// Ports
//   clk            receive clock (phy_rx_clk)
//   reset          asynchronous, active-high
//   rx_data[7:0]   receive byte, valid while rx_ctl[1]=1
//   rx_ctl[1:0]    [1]=RX_DV, [0]=RX_DV^RX_ER
//   frame_ready    buffer holds an accepted frame
//   frame_len[6:0] payload length of the held frame
//   rd_addr[6:0]   buffer read address
//   rd_data[7:0]   buffer byte at rd_addr, one cycle latency
//   ack            releases the buffer
//   cnt_clr        zeroes all counters
//   good_count     accepted frames (saturating)
//   crc_err_count  CRC failures, short frames and RX_ER frames (saturating)
//   drop_count     frames lost to a busy buffer or oversize (saturating)
//
// state      | meaning
// -----------+--------------------------------------------------------
// WAIT_IDLE  | after reset; ignore the line until RX_DV is low once
// IDLE       | between frames; wait for the first preamble byte
// PREAMBLE   | 0x55 run; 0xD5 starts the frame
// HEADER     | 14 bytes of destination, source, EtherType
// PAYLOAD    | payload plus FCS written to the buffer
// CHECK      | RX_DV fell; CRC residue and length decide acceptance
// DISCARD    | rest of a rejected frame; wait for RX_DV low

module packet_receiver #(
  parameter int          MAX_PAYLOAD = 64,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic [1:0] rx_ctl,
  output logic       frame_ready,
  output logic [6:0] frame_len,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       ack,
  input  logic       cnt_clr,
  output logic [7:0] good_count,
  output logic [7:0] crc_err_count,
  output logic [7:0] drop_count
);

  localparam int          DEPTH       = MAX_PAYLOAD + 4;
  localparam int          CNT_W       = $clog2(DEPTH + 1);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

`ifdef PACKET_RECEIVER_DEST_FILTER_EN
  localparam bit DEST_FILTER_EN = 1'b1;
`else
  localparam bit DEST_FILTER_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECK,
    S_DISCARD
  } state_t;

  state_t           r_state;
  logic [31:0]      r_crc;
  logic [3:0]       r_hdr_cnt;
  logic [CNT_W-1:0] r_stored;
  logic             r_et_hi_ok;
  logic             r_uc_ok;
  logic             r_bc_ok;
  logic             r_frame_ready;
  logic [6:0]       r_frame_len;
  logic [7:0]       r_rd_data;
  logic [7:0]       r_good;
  logic [7:0]       r_crc_err;
  logic [7:0]       r_drop;
  logic [7:0]       r_buf [0:DEPTH-1];

  logic             w_dv;
  logic             w_err;
  logic [31:0]      w_crc_next;
  logic             w_wr_en;
  logic [7:0]       w_mac_byte;
  logic             w_uc_hit;
  logic             w_bc_hit;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_dv       = rx_ctl[1];
  assign w_err      = rx_ctl[1] ^ rx_ctl[0];
  assign w_crc_next = crc_byte(r_crc, rx_data);

  // The busy check at the SFD keeps the buffer frozen while frame_ready=1;
  // the extra term only makes that explicit at the write port.
  assign w_wr_en = (r_state == S_PAYLOAD) && w_dv && !w_err &&
                   (int'(r_stored) < DEPTH) && !r_frame_ready;

  // Destination byte expected at each of the first six header positions.
  always_comb begin
    w_mac_byte = 8'h00;
    case (r_hdr_cnt)
      4'd0:    w_mac_byte = MAC_ADDR[47:40];
      4'd1:    w_mac_byte = MAC_ADDR[39:32];
      4'd2:    w_mac_byte = MAC_ADDR[31:24];
      4'd3:    w_mac_byte = MAC_ADDR[23:16];
      4'd4:    w_mac_byte = MAC_ADDR[15:8];
      4'd5:    w_mac_byte = MAC_ADDR[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  assign w_uc_hit = r_uc_ok && (rx_data == w_mac_byte);
  assign w_bc_hit = r_bc_ok && (rx_data == 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_WAIT_IDLE;
      r_crc         <= 32'hFFFFFFFF;
      r_hdr_cnt     <= 4'd0;
      r_stored      <= '0;
      r_et_hi_ok    <= 1'b0;
      r_uc_ok       <= 1'b0;
      r_bc_ok       <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_len   <= 7'd0;
      r_good        <= 8'd0;
      r_crc_err     <= 8'd0;
      r_drop        <= 8'd0;
    end else begin
      case (r_state)
        S_WAIT_IDLE: begin
          if (!w_dv) r_state <= S_IDLE;
        end
        S_IDLE: begin
          // A byte other than 0x55 here means we joined mid-frame.
          if (w_dv) r_state <= (rx_data == 8'h55) ? S_PREAMBLE : S_DISCARD;
        end
        S_PREAMBLE: begin
          if (!w_dv) begin
            r_state <= S_IDLE;
          end else if (rx_data == 8'hD5) begin
            if (r_frame_ready) begin
              r_state <= S_DISCARD;
              r_drop  <= sat_inc(r_drop);
            end else begin
              r_state   <= S_HEADER;
              r_crc     <= 32'hFFFFFFFF;
              r_hdr_cnt <= 4'd0;
              r_stored  <= '0;
              r_uc_ok   <= 1'b1;
              r_bc_ok   <= 1'b1;
            end
          end else if (rx_data != 8'h55) begin
            r_state <= S_DISCARD;
          end
        end
        S_HEADER: begin
          if (!w_dv) begin
            r_state <= S_CHECK;
          end else if (w_err) begin
            r_state   <= S_DISCARD;
            r_crc_err <= sat_inc(r_crc_err);
          end else begin
            r_crc     <= w_crc_next;
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
            if (r_hdr_cnt < 4'd6) begin
              r_uc_ok <= w_uc_hit;
              r_bc_ok <= w_bc_hit;
            end
            if (DEST_FILTER_EN && (r_hdr_cnt == 4'd5) && !(w_uc_hit || w_bc_hit))
              r_state <= S_DISCARD;
            if (r_hdr_cnt == 4'd12)
              r_et_hi_ok <= (rx_data == ETHERTYPE[15:8]);
            if (r_hdr_cnt == 4'd13)
              r_state <= (r_et_hi_ok && (rx_data == ETHERTYPE[7:0])) ? S_PAYLOAD : S_DISCARD;
          end
        end
        S_PAYLOAD: begin
          if (!w_dv) begin
            r_state <= S_CHECK;
          end else if (w_err) begin
            r_state   <= S_DISCARD;
            r_crc_err <= sat_inc(r_crc_err);
          end else if (int'(r_stored) >= DEPTH) begin
            r_state <= S_DISCARD;
            r_drop  <= sat_inc(r_drop);
          end else begin
            r_crc    <= w_crc_next;
            r_stored <= r_stored + CNT_W'(1);
          end
        end
        S_CHECK: begin
          r_state <= S_IDLE;
          // The CRC runs over the FCS too, so a good frame leaves the fixed residue.
          if ((r_crc == CRC_RESIDUE) && (r_stored >= CNT_W'(4))) begin
            r_frame_ready <= 1'b1;
            r_frame_len   <= 7'(r_stored - CNT_W'(4));
            r_good        <= sat_inc(r_good);
          end else begin
            r_crc_err <= sat_inc(r_crc_err);
          end
        end
        S_DISCARD: begin
          if (!w_dv) r_state <= S_IDLE;
        end
        default: r_state <= S_WAIT_IDLE;
      endcase

      // CHECK only commits when frame_ready was low, so this never races the set.
      if (ack && r_frame_ready) r_frame_ready <= 1'b0;

      if (cnt_clr) begin
        r_good    <= 8'd0;
        r_crc_err <= 8'd0;
        r_drop    <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_stored] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= 8'h00;
    else       r_rd_data <= (int'(rd_addr) < DEPTH) ? r_buf[rd_addr] : 8'h00;
  end

  assign frame_ready   = r_frame_ready;
  assign frame_len     = r_frame_len;
  assign rd_data       = r_rd_data;
  assign good_count    = r_good;
  assign crc_err_count = r_crc_err;
  assign drop_count    = r_drop;

endmodule

// File: tb/tb_packet_receiver.sv
module tb_packet_receiver;

  localparam int MAXP = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic [1:0] rx_ctl;
  logic       frame_ready;
  logic [6:0] frame_len;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       ack;
  logic       cnt_clr;
  logic [7:0] good_count;
  logic [7:0] crc_err_count;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  packet_receiver #(.MAX_PAYLOAD(MAXP)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ctl       (rx_ctl),
    .frame_ready  (frame_ready),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .ack          (ack),
    .cnt_clr      (cnt_clr),
    .good_count   (good_count),
    .crc_err_count(crc_err_count),
    .drop_count   (drop_count)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_len_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] frm[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC; the FCS is the complemented register, LSB byte first.
  function automatic logic [31:0] fcs_of_frm();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (frm[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frm[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] et,
                             input int plen, input int start);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) frm.push_back(8'(start + i));
    c = fcs_of_frm();
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic expect_accept(input int plen, input int start);
    exp_len_q.push_back(plen);
    for (int i = 0; i < plen; i++) exp_data_q.push_back(8'(start + i));
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] c);
    rx_data = d;
    rx_ctl  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 2'b00);
  endtask

  // err_at: frame byte driven with RX_ER; rst_at: reset held for two bytes from there.
  task automatic send_frame(input int err_at, input int rst_at);
    for (int i = 0; i < 7; i++) drive(8'h55, 2'b11);
    drive(8'hD5, 2'b11);
    foreach (frm[i]) begin
      if (i == rst_at) reset = 1'b1;
      if (i == rst_at + 2) reset = 1'b0;
      drive(frm[i], (i == err_at) ? 2'b10 : 2'b11);
    end
  endtask

  task automatic read_byte(input int a, output logic [7:0] v);
    rd_addr = 7'(a);
    @(posedge clk);
    #1;
    v = rd_data;
  endtask

  task automatic score_len(output int plen);
    plen = exp_len_q.pop_front();
    check_val("frame_len", frame_len, plen);
  endtask

  task automatic score_bytes(input int plen);
    logic [7:0] v;
    for (int i = 0; i < plen; i++) begin
      read_byte(i, v);
      check_val($sformatf("buf[%0d]", i), v, exp_data_q.pop_front());
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int g, input int c, input int d);
    check_val({tag, "_good"}, good_count, g);
    check_val({tag, "_crcerr"}, crc_err_count, c);
    check_val({tag, "_drop"}, drop_count, d);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         plen;
    logic [7:0] v;

    reset   = 1'b1;
    rx_data = 8'h00;
    rx_ctl  = 2'b00;
    rd_addr = 7'd0;
    ack     = 1'b0;
    cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", frame_ready, 0);
    check_val("rst_len", frame_len, 0);
    check_val("rst_rd_data", rd_data, 0);
    check_counts("rst", 0, 0, 0);
    reset = 1'b0;
    idle(2);

    // Valid broadcast frame, 46-byte payload; ready exactly two cycles after RX_DV falls.
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 0);
    expect_accept(46, 0);
    send_frame(-1, -1);
    idle(1);
    check_val("t1_ready_early", frame_ready, 0);
    idle(1);
    check_val("t1_ready", frame_ready, 1);
    check_counts("t1", 1, 0, 0);
    score_len(plen);
    score_bytes(plen);
    read_byte(5, v);
    check_val("t1_rd5", v, 8'h05);
    pulse_ack();
    check_val("t1_ack", frame_ready, 0);

    // Corrupted FCS.
    clear_counters();
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 0);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    send_frame(-1, -1);
    idle(2);
    check_val("t2_ready", frame_ready, 0);
    check_counts("t2", 0, 1, 0);

    // Busy buffer: frame B dropped while A is held, C accepted after ack.
    clear_counters();
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 0);
    expect_accept(46, 0);
    send_frame(-1, -1);
    idle(2);
    check_val("t3a_ready", frame_ready, 1);
    score_len(plen);
    score_bytes(plen);
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 8'h80);
    send_frame(-1, -1);
    idle(2);
    check_val("t3b_ready", frame_ready, 1);
    check_val("t3b_len", frame_len, 46);
    check_counts("t3b", 1, 0, 1);
    read_byte(5, v);
    check_val("t3b_rd5", v, 8'h05);
    pulse_ack();
    check_val("t3b_ack", frame_ready, 0);
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 20, 8'h40);
    expect_accept(20, 8'h40);
    send_frame(-1, -1);
    idle(2);
    check_val("t3c_ready", frame_ready, 1);
    check_counts("t3c", 2, 0, 1);
    score_len(plen);
    score_bytes(plen);
    pulse_ack();

    // Oversize, then a maximum-length frame acked in the cycle ready rises.
    clear_counters();
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, MAXP + 1, 0);
    send_frame(-1, -1);
    idle(2);
    check_val("t4_ready", frame_ready, 0);
    check_counts("t4", 0, 0, 1);
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, MAXP, 8'h20);
    expect_accept(MAXP, 8'h20);
    send_frame(-1, -1);
    idle(2);
    check_val("t4b_ready", frame_ready, 1);
    check_counts("t4b", 1, 0, 1);
    score_len(plen);
    pulse_ack();
    check_val("t4b_ack_rise", frame_ready, 0);
    score_bytes(plen);

    // Reset mid-payload, released with RX_DV still high; then RX_ER on payload byte 20.
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 0);
    send_frame(-1, 24);
    idle(2);
    check_val("t5a_ready", frame_ready, 0);
    check_counts("t5a", 0, 0, 0);
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 0);
    send_frame(14 + 20, -1);
    idle(2);
    check_val("t5b_ready", frame_ready, 0);
    check_counts("t5b", 0, 1, 0);

    // Unicast to another station.
    clear_counters();
    build_frame(48'h02_00_00_00_00_02, 16'h88B5, 46, 3);
`ifdef PACKET_RECEIVER_DEST_FILTER_EN
    send_frame(-1, -1);
    idle(2);
    check_val("t6_ready", frame_ready, 0);
    check_counts("t6", 0, 0, 0);
`else
    expect_accept(46, 3);
    send_frame(-1, -1);
    idle(2);
    check_val("t6_ready", frame_ready, 1);
    check_counts("t6", 1, 0, 0);
    score_len(plen);
    score_bytes(plen);
    pulse_ack();
`endif

    // Wrong EtherType: silently discarded.
    clear_counters();
    build_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 46, 0);
    send_frame(-1, -1);
    idle(2);
    check_val("t7_ready", frame_ready, 0);
    check_counts("t7", 0, 0, 0);

    // Back-to-back with a single idle cycle: bad FCS followed by a good frame.
    clear_counters();
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 30, 0);
    frm[frm.size()-2] = frm[frm.size()-2] ^ 8'h80;
    send_frame(-1, -1);
    idle(1);
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 30, 8'h60);
    expect_accept(30, 8'h60);
    send_frame(-1, -1);
    idle(2);
    check_val("t8_ready", frame_ready, 1);
    check_counts("t8", 1, 1, 0);
    score_len(plen);
    score_bytes(plen);
    pulse_ack();

    // Zero-length payload: header plus FCS exactly.
    clear_counters();
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 0, 0);
    expect_accept(0, 0);
    send_frame(-1, -1);
    idle(2);
    check_val("t9_ready", frame_ready, 1);
    check_counts("t9", 1, 0, 0);
    score_len(plen);
    pulse_ack();

    // Short frames saturate crc_err_count; cnt_clr beats a same-cycle increment.
    clear_counters();
    for (int n = 0; n < 260; n++) begin
      drive(8'h55, 2'b11);
      drive(8'hD5, 2'b11);
      drive(8'hFF, 2'b11);
      idle(2);
      if (n == 0) check_val("t10_first", crc_err_count, 1);
    end
    check_val("t10_sat", crc_err_count, 255);
    drive(8'h55, 2'b11);
    drive(8'hD5, 2'b11);
    drive(8'hFF, 2'b11);
    idle(1);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    check_val("t10_clr_prio", crc_err_count, 0);

    check_val("sb_drained", exp_len_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
